// File: rtl/fp_pkg.sv
// Shared floating-point compare definitions: result codes, mode encodings
// and the canonical quiet-NaN pattern.
package fp_pkg;

  // Compare result encodings presented on comp
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_LT = 2'b11;
  localparam logic [1:0] CMP_UN = 2'b10;

  // Compare mode encodings presented on mode
  localparam logic MODE_MAG    = 1'b0;
  localparam logic MODE_SIGNED = 1'b1;

  // Widest operand the qNaN helper can build; callers slice the low bits.
  localparam int FP_MAX_W = 128;

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set, rest 0.
  function automatic logic [FP_MAX_W-1:0] canon_qnan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    logic [FP_MAX_W-1:0] one;
    v   = '0;
    one = {{(FP_MAX_W-1){1'b0}}, 1'b1};
    for (int i = 0; i < exp_w; i++) begin
      v = v | (one << (man_w + i));
    end
    v = v | (one << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier: NaN / signalling NaN / zero
// flags plus the sign bit and the unsigned {exp,man} magnitude.
module fp_classify #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic [WIDTH-1:0] i_op,
  output logic             o_is_nan,
  output logic             o_is_snan,
  output logic             o_is_zero,
  output logic             o_sign,
  output logic [WIDTH-2:0] o_mag
);

  logic [EXP_WIDTH-1:0] w_exp;
  logic [MAN_WIDTH-1:0] w_man;
  logic                 w_exp_ones;
  logic                 w_exp_zero;
  logic                 w_man_zero;

  assign w_exp      = i_op[WIDTH-2 -: EXP_WIDTH];
  assign w_man      = i_op[MAN_WIDTH-1:0];
  assign w_exp_ones = &w_exp;
  assign w_exp_zero = ~|w_exp;
  assign w_man_zero = ~|w_man;

  // A NaN whose quiet bit (mantissa MSB) is clear is signalling.
  assign o_is_nan  = w_exp_ones & ~w_man_zero;
  assign o_is_snan = o_is_nan & ~w_man[MAN_WIDTH-1];
  assign o_is_zero = w_exp_zero & w_man_zero;
  assign o_sign    = i_op[WIDTH-1];
  // Subnormals keep their exact encoding, so an unsigned compare of
  // {exp,man} orders every non-NaN magnitude correctly.
  assign o_mag     = i_op[WIDTH-2:0];

endmodule

// File: rtl/fp_cmp_pipe.sv
// Two-stage pipelined IEEE-754 comparator with valid/ready handshake.
// S1 captures operand classification and the magnitude relation; S2
// resolves the compare code, min/max selection and the invalid flag.
module fp_cmp_pipe
  import fp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       comp,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
  output logic             invalid
);

  generate
    if (WIDTH != 1 + EXP_WIDTH + MAN_WIDTH) begin : g_bad_width
      $error("fp_cmp_pipe: WIDTH must equal 1+EXP_WIDTH+MAN_WIDTH");
    end
  endgenerate

  localparam logic [FP_MAX_W-1:0] QNAN_FULL = canon_qnan(EXP_WIDTH, MAN_WIDTH);
  localparam logic [WIDTH-1:0]    QNAN      = QNAN_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]    POS_ZERO  = '0;
  localparam logic [WIDTH-1:0]    NEG_ZERO  = {1'b1, {(WIDTH-1){1'b0}}};

  // ---------------- operand classification (index 0 = a, 1 = b) -------------
  logic [WIDTH-1:0] w_op   [2];
  logic [WIDTH-2:0] w_mag  [2];
  logic [1:0]       w_is_nan;
  logic [1:0]       w_is_snan;
  logic [1:0]       w_is_zero;
  logic [1:0]       w_sign;

  assign w_op[0] = a;
  assign w_op[1] = b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cls
      fp_classify #(
        .WIDTH    (WIDTH),
        .EXP_WIDTH(EXP_WIDTH),
        .MAN_WIDTH(MAN_WIDTH)
      ) u_cls (
        .i_op     (w_op[gi]),
        .o_is_nan (w_is_nan[gi]),
        .o_is_snan(w_is_snan[gi]),
        .o_is_zero(w_is_zero[gi]),
        .o_sign   (w_sign[gi]),
        .o_mag    (w_mag[gi])
      );
    end
  endgenerate

  logic w_mag_gt;
  logic w_mag_eq;

  assign w_mag_gt = (w_mag[0] > w_mag[1]);
  assign w_mag_eq = (w_mag[0] == w_mag[1]);

  // ---------------- handshake ----------------------------------------------
  logic r_s1_valid;
  logic r_out_valid;
  logic w_s2_load;

  // S2 (and therefore S1) may advance whenever the output slot is free or
  // being drained this cycle; in_ready follows combinationally.
  assign w_s2_load = ~r_out_valid | out_ready;
  assign in_ready  = ~r_s1_valid | w_s2_load;

  // ---------------- stage 1 registers --------------------------------------
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_mode;
  logic [1:0]       r_s1_nan;
  logic [1:0]       r_s1_snan;
  logic [1:0]       r_s1_zero;
  logic [1:0]       r_s1_sign;
  logic             r_s1_mag_gt;
  logic             r_s1_mag_eq;

  // Stage 1: capture a new pair whenever the stage is free or advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_mode   <= 1'b0;
      r_s1_nan    <= '0;
      r_s1_snan   <= '0;
      r_s1_zero   <= '0;
      r_s1_sign   <= '0;
      r_s1_mag_gt <= 1'b0;
      r_s1_mag_eq <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a      <= a;
        r_s1_b      <= b;
        r_s1_mode   <= mode;
        r_s1_nan    <= w_is_nan;
        r_s1_snan   <= w_is_snan;
        r_s1_zero   <= w_is_zero;
        r_s1_sign   <= w_sign;
        r_s1_mag_gt <= w_mag_gt;
        r_s1_mag_eq <= w_mag_eq;
      end
    end
  end

  // ---------------- stage 2 resolution -------------------------------------
  logic [1:0]       w_mag_ord;
  logic [1:0]       w_comp;
  logic [WIDTH-1:0] w_min;
  logic [WIDTH-1:0] w_max;
  logic             w_invalid;
  logic             w_both_zero;

  assign w_both_zero = &r_s1_zero;
  assign w_invalid   = |r_s1_snan;

  // Resolve compare code and min/max from the stage-1 classification.
  always_comb begin
    w_mag_ord = CMP_EQ;
    w_comp    = CMP_EQ;
    w_min     = r_s1_a;
    w_max     = r_s1_b;

    if (r_s1_mag_gt) begin
      w_mag_ord = CMP_GT;
    end else if (!r_s1_mag_eq) begin
      w_mag_ord = CMP_LT;
    end

    if (|r_s1_nan) begin
      // Unordered; min/max prefer the number, else the canonical qNaN.
      w_comp = CMP_UN;
      if (&r_s1_nan) begin
        w_min = QNAN;
        w_max = QNAN;
      end else if (r_s1_nan[0]) begin
        w_min = r_s1_b;
        w_max = r_s1_b;
      end else begin
        w_min = r_s1_a;
        w_max = r_s1_a;
      end
    end else begin
      if (r_s1_mode == MODE_SIGNED) begin
        if (w_both_zero) begin
          w_comp = CMP_EQ;
        end else if (r_s1_sign[0] != r_s1_sign[1]) begin
          w_comp = r_s1_sign[0] ? CMP_LT : CMP_GT;
        end else if (r_s1_sign[0]) begin
          // Both negative: larger magnitude is the smaller value.
          case (w_mag_ord)
            CMP_GT:  w_comp = CMP_LT;
            CMP_LT:  w_comp = CMP_GT;
            default: w_comp = CMP_EQ;
          endcase
        end else begin
          w_comp = w_mag_ord;
        end
      end else begin
        w_comp = w_mag_ord;
      end

      case (w_comp)
        CMP_GT: begin
          w_min = r_s1_b;
          w_max = r_s1_a;
        end
        CMP_LT: begin
          w_min = r_s1_a;
          w_max = r_s1_b;
        end
        default: begin
          if ((r_s1_mode == MODE_SIGNED) && w_both_zero) begin
            w_min = NEG_ZERO;
            w_max = POS_ZERO;
          end else begin
            w_min = r_s1_a;
            w_max = r_s1_b;
          end
        end
      endcase
    end
  end

  // ---------------- stage 2 registers --------------------------------------
  logic [1:0]       r_comp;
  logic [WIDTH-1:0] r_min;
  logic [WIDTH-1:0] r_max;
  logic             r_invalid;

  // Stage 2: load when the output slot frees; data holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_comp      <= CMP_EQ;
      r_min       <= '0;
      r_max       <= '0;
      r_invalid   <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_comp    <= w_comp;
        r_min     <= w_min;
        r_max     <= w_max;
        r_invalid <= w_invalid;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign comp      = r_comp;
  assign min_out   = r_min;
  assign max_out   = r_max;
  assign invalid   = r_invalid;

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Scoreboard bench for fp_cmp_pipe: accepted pairs push an expected result,
// a negedge monitor pops and compares each transferred result.
module tb_fp_cmp_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  comp;
  logic [31:0] min_out;
  logic [31:0] max_out;
  logic        invalid;

  fp_cmp_pipe #(.WIDTH(32), .EXP_WIDTH(8), .MAN_WIDTH(23)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .comp     (comp),
    .min_out  (min_out),
    .max_out  (max_out),
    .invalid  (invalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  comp;
    logic [31:0] mn;
    logic [31:0] mx;
    logic        inv;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_res   = 0;

  bit   dir_use = 1'b0;
  exp_t dir_exp;
  bit   rdy_rand = 1'b0;
  bit   rdy_level = 1'b1;

  bit          held_valid = 1'b0;
  logic [1:0]  held_comp;
  logic [31:0] held_min;
  logic [31:0] held_max;
  logic        held_inv;

  logic [31:0] specials [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                                32'h7FC00000, 32'h7F800001, 32'h3F800000, 32'hBF800000};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] c, input logic [31:0] mn,
                              input logic [31:0] mx, input logic inv);
    exp_t r;
    r.comp = c; r.mn = mn; r.mx = mx; r.inv = inv;
    return r;
  endfunction

  // Reference: map each number to a signed integer key that orders the
  // values (mode 1) or magnitudes (mode 0), then compare keys.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic m);
    exp_t   r;
    bit     xn, yn;
    longint kx, ky;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    r.inv = (xn && !x[22]) || (yn && !y[22]);
    if (xn || yn) begin
      r.comp = 2'b10;
      if (xn && yn) begin r.mn = 32'h7FC00000; r.mx = 32'h7FC00000; end
      else if (xn) begin r.mn = y; r.mx = y; end
      else begin r.mn = x; r.mx = x; end
    end else begin
      kx = longint'({1'b0, x[30:0]});
      ky = longint'({1'b0, y[30:0]});
      if (m && x[31]) kx = -kx;
      if (m && y[31]) ky = -ky;
      if (kx > ky) begin r.comp = 2'b01; r.mn = y; r.mx = x; end
      else if (kx < ky) begin r.comp = 2'b11; r.mn = x; r.mx = y; end
      else begin
        r.comp = 2'b00;
        if (m && x[30:0] == 31'd0 && y[30:0] == 31'd0) begin
          r.mn = 32'h80000000; r.mx = 32'h00000000;
        end else begin
          r.mn = x; r.mx = y;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0: v = $urandom;
      1: v = specials[$urandom_range(0, 7)];
      2: v = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom)};
      3: v = {1'($urandom_range(0, 1)), 8'h00, 23'($urandom_range(0, 15))};
      default: v = {1'($urandom_range(0, 1)), 8'd126 + 8'($urandom_range(0, 3)), 23'($urandom_range(0, 3))};
    endcase
    return v;
  endfunction

  // Ready driver: changes out_ready just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
    end
  end

  // Accept logger and result monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (held_valid) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_comp", {30'd0, comp}, {30'd0, held_comp});
        check("stall_min", min_out, held_min);
        check("stall_max", max_out, held_max);
        check("stall_inv", {31'd0, invalid}, {31'd0, held_inv});
        held_valid = 1'b0;
      end
      if (in_valid && in_ready)
        sb_q.push_back(dir_use ? dir_exp : model(a, b, mode));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          n_res++;
          $display("[TB] result %0d: comp=%b min=%h max=%h inv=%b", n_res, comp, min_out, max_out, invalid);
          check("comp", {30'd0, comp}, {30'd0, e.comp});
          check("min_out", min_out, e.mn);
          check("max_out", max_out, e.mx);
          check("invalid", {31'd0, invalid}, {31'd0, e.inv});
        end
      end else if (out_valid && !out_ready) begin
        held_valid = 1'b1;
        held_comp  = comp;
        held_min   = min_out;
        held_max   = max_out;
        held_inv   = invalid;
      end
    end
  end

  // Present a pair (called just after a rising edge); returns after the
  // accepting edge, reporting how many edges it took.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic m,
                      input bit use_dir, input exp_t e, output int cycles);
    bit acc;
    a = x; b = y; mode = m; in_valid = 1'b1;
    dir_use = use_dir; dir_exp = e;
    cycles = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cycles++;
    end while (!acc && cycles < 200);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    dir_use = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", sb_q.size(), 32'd0);
  endtask

  task automatic send_rand(input int count, input bit require_fast);
    logic [31:0] x, y;
    int cyc;
    for (int i = 0; i < count; i++) begin
      x = pick();
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = x ^ 32'h80000000;
        default: y = pick();
      endcase
      send(x, y, 1'($urandom_range(0, 1)), 1'b0, '0, cyc);
      if (require_fast) check("throughput_accept_cycles", cyc, 32'd1);
    end
  endtask

  initial begin
    int cyc;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_comp", {30'd0, comp}, 32'd0);
    check("rst_min", min_out, 32'd0);
    check("rst_max", max_out, 32'd0);
    check("rst_invalid", {31'd0, invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    rdy_rand = 1'b0; rdy_level = 1'b1;
    send(32'h3F800000, 32'h40000000, 1'b1, 1'b1, mk(2'b11, 32'h3F800000, 32'h40000000, 1'b0), cyc);
    send(32'h80000000, 32'h00000000, 1'b1, 1'b1, mk(2'b00, 32'h80000000, 32'h00000000, 1'b0), cyc);
    send(32'hBF800000, 32'hC0000000, 1'b1, 1'b1, mk(2'b01, 32'hC0000000, 32'hBF800000, 1'b0), cyc);
    send(32'hBF800000, 32'hC0000000, 1'b0, 1'b1, mk(2'b11, 32'hBF800000, 32'hC0000000, 1'b0), cyc);
    send(32'h7FC00000, 32'h3F800000, 1'b1, 1'b1, mk(2'b10, 32'h3F800000, 32'h3F800000, 1'b0), cyc);
    send(32'h7F800001, 32'h7FC00000, 1'b1, 1'b1, mk(2'b10, 32'h7FC00000, 32'h7FC00000, 1'b1), cyc);
    send(32'h7F800001, 32'hFFC00000, 1'b0, 1'b1, mk(2'b10, 32'h7FC00000, 32'h7FC00000, 1'b1), cyc);
    send(32'h00000001, 32'h00000002, 1'b1, 1'b1, mk(2'b11, 32'h00000001, 32'h00000002, 1'b0), cyc);
    send(32'hBF800000, 32'h3F800000, 1'b0, 1'b1, mk(2'b00, 32'hBF800000, 32'h3F800000, 1'b0), cyc);
    send(32'h80000001, 32'h00000000, 1'b1, 1'b1, mk(2'b11, 32'h80000001, 32'h00000000, 1'b0), cyc);
    idle();
    drain();

    // Full throughput with out_ready held high
    send_rand(12, 1'b1);
    idle();
    drain();

    // Backpressure with pseudo-random out_ready
    rdy_rand = 1'b1;
    send_rand(40, 1'b0);
    idle();
    rdy_rand = 1'b0; rdy_level = 1'b1;
    drain();

    // Reset mid-flight
    send(32'h40400000, 32'h3F800000, 1'b1, 1'b0, '0, cyc);
    send(32'hC0400000, 32'h3F800000, 1'b1, 1'b0, '0, cyc);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    held_valid = 1'b0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_comp", {30'd0, comp}, 32'd0);
    check("midrst_min", min_out, 32'd0);
    check("midrst_max", max_out, 32'd0);
    check("midrst_invalid", {31'd0, invalid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_result", {31'd0, out_valid}, 32'd0);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    end
    @(posedge clk);
    #1;

    // Mixed traffic after reset
    rdy_rand = 1'b1;
    send_rand(30, 1'b0);
    idle();
    rdy_rand = 1'b0; rdy_level = 1'b1;
    drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
